cla_response_checker: RTL and testbench

//  Response-side companion to the CLA stimulus generators: samples each applied

---
 rtl/cla_test_pkg.sv | 18 +
 rtl/cla_response_checker_if.sv | 30 +++
 rtl/cla_misr16.sv | 23 ++
 rtl/cla_response_checker.sv | 110 +++++++++++
 tb/tb_cla_response_checker.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/cla_test_pkg.sv
// Shared types and defaults for the CLA response checker: FSM encoding,
// default MISR polynomial and the exhaustive vector count for a given width.
package cla_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] MISR_POLY_DEF = 16'h1021;

  // Exhaustive coverage of a, b and carry-in.
  function automatic int num_vec_for(input int width);
    return 1 << (2 * width + 1);
  endfunction

endpackage

// File: rtl/cla_response_checker_if.sv
// Stimulus/response bundle between an adder-under-test harness and the checker.
interface cla_response_checker_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 10
);
  logic                 start;
  logic                 in_valid;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 c;
  logic [WIDTH-1:0]     sum;
  logic                 c_out;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [CNT_W-1:0]     err_count;
  logic [CNT_W-1:0]     first_fail_idx;
  logic [2*WIDTH:0]     first_fail_vec;
  logic [15:0]          signature;

  modport master (
    output start, in_valid, a, b, c, sum, c_out,
    input  busy, done, pass, err_count, first_fail_idx, first_fail_vec, signature
  );

  modport slave (
    input  start, in_valid, a, b, c, sum, c_out,
    output busy, done, pass, err_count, first_fail_idx, first_fail_vec, signature
  );
endinterface

// File: rtl/cla_misr16.sv
// 16-bit multiple-input signature register; clr wins over en, sync active-low reset.
module cla_misr16 #(
  parameter logic [15:0] POLY = 16'h1021
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] sig
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig <= 16'h0000;
    end else if (clr) begin
      sig <= 16'h0000;
    end else if (en) begin
      sig <= {sig[14:0], 1'b0} ^ (sig[15] ? POLY : 16'h0000) ^ din;
    end
  end

endmodule

// File: rtl/cla_response_checker.sv
// Checks adder results against a golden a+b+c, counts mismatches, records the
// first failure and compacts every result into a MISR signature.
//
//   state   | meaning
//   IDLE    | after reset, waiting for start
//   RUN     | sampling vectors on in_valid
//   DONE    | run complete, results frozen until next start
module cla_response_checker
  import cla_test_pkg::*;
#(
  parameter int          WIDTH     = 4,
  parameter int          NUM_VEC   = num_vec_for(WIDTH),
  parameter int          CNT_W     = 10,
  parameter logic [15:0] MISR_POLY = MISR_POLY_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  cla_response_checker_if.slave bus
);

  state_t             state;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic [CNT_W-1:0]   err_count_q;
  logic [CNT_W-1:0]   ffi_q;
  logic [2*WIDTH:0]   ffv_q;
  logic [CNT_W-1:0]   vec_idx;

  logic [WIDTH:0]     expected;
  logic               mismatch;
  logic               accept;
  logic               start_ok;
  logic               last_vec;
  logic [CNT_W-1:0]   err_next;
  logic [15:0]        misr_din;
  logic [15:0]        sig;

  assign expected = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.c};
  assign mismatch = ({bus.c_out, bus.sum} != expected);
  assign accept   = (state == ST_RUN) && bus.in_valid;
  assign start_ok = (state != ST_RUN) && bus.start;
  assign last_vec = (vec_idx == CNT_W'(NUM_VEC - 1));
  assign err_next = (mismatch && (err_count_q != '1)) ? err_count_q + 1'b1 : err_count_q;
  assign misr_din = 16'({bus.c_out, bus.sum});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      ffi_q       <= '0;
      ffv_q       <= '0;
      vec_idx     <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state       <= ST_RUN;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            ffi_q       <= '0;
            ffv_q       <= '0;
            vec_idx     <= '0;
          end
        end
        ST_RUN: begin
          if (bus.in_valid) begin
            err_count_q <= err_next;
            // Only the first mismatch of a run is captured.
            if (mismatch && (err_count_q == '0)) begin
              ffi_q <= vec_idx;
              ffv_q <= {bus.c, bus.b, bus.a};
            end
            vec_idx <= vec_idx + 1'b1;
            if (last_vec) begin
              state  <= ST_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              pass_q <= (err_next == '0);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  cla_misr16 #(.POLY(MISR_POLY)) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok),
    .en    (accept),
    .din   (misr_din),
    .sig   (sig)
  );

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_count_q;
  assign bus.first_fail_idx = ffi_q;
  assign bus.first_fail_vec = ffv_q;
  assign bus.signature      = sig;

endmodule

// File: tb/tb_cla_response_checker.sv
// Directed bench for cla_response_checker: table of full-run scenarios plus
// hand-written reset, held-DONE and saturation sequences.
module tb_cla_response_checker;

  localparam int NV = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  cla_response_checker_if #(.WIDTH(4), .CNT_W(10)) bus1 ();
  cla_response_checker_if #(.WIDTH(4), .CNT_W(4))  bus2 ();

  cla_response_checker #(.WIDTH(4), .NUM_VEC(512), .CNT_W(10), .MISR_POLY(16'h1021)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );

  cla_response_checker #(.WIDTH(4), .NUM_VEC(16), .CNT_W(4), .MISR_POLY(16'h1021)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
  );

  typedef struct {
    string name;
    int    fault;      // 0 none, 1 sum LSB flipped at vector 37, 2 c_out stuck-at-0
    bit    toggle;
    bit    midstart;
    int    exp_err;
    int    exp_idx;
    bit    exp_pass;
    int    exp_cycles;
  } scen_t;

  scen_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] misr_model(input logic [15:0] s, input logic [4:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {11'b0, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input int fault);
    logic [8:0] v;
    logic [4:0] s5;
    v  = i[8:0];
    s5 = {1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'b0, v[8]};
    bus1.a     = v[3:0];
    bus1.b     = v[7:4];
    bus1.c     = v[8];
    bus1.sum   = s5[3:0];
    bus1.c_out = s5[4];
    if (fault == 1 && i == 37) bus1.sum[0] = ~bus1.sum[0];
    if (fault == 2)            bus1.c_out = 1'b0;
    if (fault == 3)            bus1.sum[0] = ~bus1.sum[0];
  endtask

  // Runs one pass over all vectors; rst_at >= 0 pulses reset alongside that vector and returns.
  task automatic run_main(input int fault, input bit toggle, input bit midstart, input int rst_at,
                          output logic [15:0] msig, output int cycles);
    int t0;
    msig = 16'h0;
    cycles = 0;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    t0 = cyc;
    for (int i = 0; i < NV; i++) begin
      set_vec(i, fault);
      bus1.in_valid = 1'b1;
      msig = misr_model(msig, {bus1.c_out, bus1.sum});
      if (i == rst_at) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus1.in_valid = 1'b0;
        return;
      end
      if (i == NV - 1) chk("done_early", {31'b0, bus1.done}, 32'd0);
      tick();
      if (toggle && i < NV - 1) begin
        bus1.in_valid = 1'b0;
        if (midstart && i == 200) bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
      end
    end
    bus1.in_valid = 1'b0;
    cycles = cyc - t0;
  endtask

  logic [15:0] sig_ref;
  logic [15:0] msig;
  logic [15:0] held_sig;
  int          cycles;

  initial begin
    tbl[0] = '{"good_exhaustive", 0, 1'b0, 1'b0, 0,   0,  1'b1, 512};
    tbl[1] = '{"fault_at_37",     1, 1'b0, 1'b0, 1,   37, 1'b0, 512};
    tbl[2] = '{"cout_stuck0",     2, 1'b0, 1'b0, 256, 31, 1'b0, 512};
    tbl[3] = '{"valid_toggle",    0, 1'b1, 1'b1, 0,   0,  1'b1, 1023};

    {bus1.start, bus1.in_valid, bus1.a, bus1.b, bus1.c, bus1.sum, bus1.c_out} = '0;
    {bus2.start, bus2.in_valid, bus2.a, bus2.b, bus2.c, bus2.sum, bus2.c_out} = '0;
    sig_ref = 16'h0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    chk("rst_busy", {31'b0, bus1.busy}, 32'd0);
    chk("rst_done", {31'b0, bus1.done}, 32'd0);
    chk("rst_pass", {31'b0, bus1.pass}, 32'd0);
    chk("rst_err",  {22'b0, bus1.err_count}, 32'd0);
    chk("rst_sig",  {16'b0, bus1.signature}, 32'd0);

    for (int k = 0; k < 4; k++) begin
      run_main(tbl[k].fault, tbl[k].toggle, tbl[k].midstart, -1, msig, cycles);
      if (k == 0) sig_ref = msig;
      chk({tbl[k].name, "_cycles"}, cycles, tbl[k].exp_cycles);
      chk({tbl[k].name, "_done"}, {31'b0, bus1.done}, 32'd1);
      chk({tbl[k].name, "_busy"}, {31'b0, bus1.busy}, 32'd0);
      chk({tbl[k].name, "_pass"}, {31'b0, bus1.pass}, {31'b0, tbl[k].exp_pass});
      chk({tbl[k].name, "_err"},  {22'b0, bus1.err_count}, tbl[k].exp_err);
      chk({tbl[k].name, "_ffidx"}, {22'b0, bus1.first_fail_idx}, tbl[k].exp_idx);
      chk({tbl[k].name, "_ffvec"}, {23'b0, bus1.first_fail_vec}, tbl[k].exp_idx);
      chk({tbl[k].name, "_sig"},  {16'b0, bus1.signature}, {16'b0, msig});
      if (tbl[k].toggle) chk({tbl[k].name, "_sig_vs_good"}, {16'b0, bus1.signature}, {16'b0, sig_ref});
    end

    // DONE holds: garbage vectors must not disturb frozen results.
    held_sig = bus1.signature;
    set_vec(5, 3);
    bus1.in_valid = 1'b1;
    tick();
    tick();
    bus1.in_valid = 1'b0;
    chk("hold_done", {31'b0, bus1.done}, 32'd1);
    chk("hold_sig",  {16'b0, bus1.signature}, {16'b0, held_sig});
    chk("hold_err",  {22'b0, bus1.err_count}, 32'd0);

    // Reset mid-run with errors accumulated.
    run_main(3, 1'b0, 1'b0, 100, msig, cycles);
    chk("midrst_busy",  {31'b0, bus1.busy}, 32'd0);
    chk("midrst_done",  {31'b0, bus1.done}, 32'd0);
    chk("midrst_err",   {22'b0, bus1.err_count}, 32'd0);
    chk("midrst_ffidx", {22'b0, bus1.first_fail_idx}, 32'd0);
    chk("midrst_ffvec", {23'b0, bus1.first_fail_vec}, 32'd0);
    chk("midrst_sig",   {16'b0, bus1.signature}, 32'd0);

    // IDLE ignores in_valid.
    set_vec(9, 3);
    bus1.in_valid = 1'b1;
    tick();
    tick();
    bus1.in_valid = 1'b0;
    chk("idle_ign_sig", {16'b0, bus1.signature}, 32'd0);
    chk("idle_ign_err", {22'b0, bus1.err_count}, 32'd0);

    run_main(0, 1'b0, 1'b0, -1, msig, cycles);
    chk("post_rst_sig",  {16'b0, bus1.signature}, {16'b0, sig_ref});
    chk("post_rst_pass", {31'b0, bus1.pass}, 32'd1);

    // Narrow counter: 16 wrong vectors saturate a 4-bit error count at 15.
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus2.a = i[3:0];
      bus2.b = 4'd0;
      bus2.c = 1'b0;
      bus2.sum = i[3:0] ^ 4'd1;
      bus2.c_out = 1'b0;
      bus2.in_valid = 1'b1;
      tick();
    end
    bus2.in_valid = 1'b0;
    chk("sat_done",  {31'b0, bus2.done}, 32'd1);
    chk("sat_err",   {28'b0, bus2.err_count}, 32'd15);
    chk("sat_ffidx", {28'b0, bus2.first_fail_idx}, 32'd0);
    chk("sat_pass",  {31'b0, bus2.pass}, 32'd0);
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    chk("restart_err",  {28'b0, bus2.err_count}, 32'd0);
    chk("restart_busy", {31'b0, bus2.busy}, 32'd1);
    chk("restart_done", {31'b0, bus2.done}, 32'd0);
    chk("restart_sig",  {16'b0, bus2.signature}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
